// File: rtl/sr_pkg.sv
// Shared types and constants for the iterative right shifter.
// Imported by the interface, the step cell and the sequencer.
package sr_pkg;

  localparam int N_DEF = 32;
  localparam int SHW   = $clog2(N_DEF);

  localparam logic SR_LOGIC = 1'b0;
  localparam logic SR_ARITH = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } sr_state_t;

endpackage

// File: rtl/sr_seq_if.sv
// Start/done request bundle between execute control and the shifter.
// Master issues the operation, slave returns status and result.
interface sr_seq_if
  import sr_pkg::*;
#(
  parameter int n   = N_DEF,
  parameter int SHW = $clog2(n)
);

  logic           start;
  logic [n-1:0]   num;
  logic [SHW-1:0] shamt;
  logic           arith;
  logic           busy;
  logic           done;
  logic [n-1:0]   result;

  modport master (
    output start, num, shamt, arith,
    input  busy, done, result
  );

  modport slave (
    input  start, num, shamt, arith,
    output busy, done, result
  );

endinterface

// File: rtl/sr1.sv
// Single-bit right step; fill bit is the MSB in arithmetic
// mode and zero in logical mode.
module sr1
  import sr_pkg::*;
#(
  parameter int n = N_DEF
) (
  input  logic [n-1:0] in_i,
  input  logic         arith_i,
  output logic [n-1:0] out_o
);

  logic fill;

  assign fill  = (arith_i == SR_ARITH) & in_i[n-1];
  assign out_o = {fill, in_i[n-1:1]};

endmodule

// File: rtl/sr_seq.sv
// Multi-cycle right shifter: one bit per clock, logical or
// arithmetic, result held until the next accepted start.
module sr_seq
  import sr_pkg::*;
#(
  parameter int n = N_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  sr_seq_if.slave    bus
);

  localparam int SW = $clog2(n);

  sr_state_t      state_q, state_d;
  logic [SW-1:0]  cnt_q, cnt_d;
  logic [n-1:0]   work_q, work_d;
  logic           mode_q, mode_d;
  logic           busy_q, done_q;
  logic [n-1:0]   res_q;
  logic [n-1:0]   step;

  sr1 #(.n(n)) u_sr1 (
    .in_i    (work_q),
    .arith_i (mode_q),
    .out_o   (step)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    mode_d  = mode_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          work_d  = bus.num;
          cnt_d   = bus.shamt;
          mode_d  = bus.arith;
          state_d = (bus.shamt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        work_d = step;
        cnt_d  = cnt_q - SW'(1);
        if (cnt_q == SW'(1)) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status and result are registered from the next state so
  // they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      mode_q  <= SR_LOGIC;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      mode_q  <= mode_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
      if (state_d == DONE) res_q <= work_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = res_q;

endmodule

// File: tb/tb_sr_seq.sv
// Randomized and directed bench for sr_seq against an
// arithmetic reference of the right-shift rules.
module tb_sr_seq;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  sr_seq_if #(.n(32)) bus ();

  sr_seq #(.n(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_sr(input logic [31:0] v,
                                         input int s,
                                         input logic a);
    logic signed [31:0] sv;
    sv = $signed(v);
    if (a) ref_sr = sv >>> s;
    else   ref_sr = v >> s;
  endfunction

  task automatic do_op(input logic [31:0] v,
                       input logic [4:0]  s,
                       input logic        a,
                       input logic [31:0] exp,
                       input string       tag);
    int cyc;
    int busy_bad;
    bit seen;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.num   = v;
    bus.shamt = s;
    bus.arith = a;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.num   = $urandom;
    bus.shamt = 5'($urandom);
    bus.arith = 1'($urandom);
    cyc = 0;
    busy_bad = 0;
    seen = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.busy !== 1'b1) busy_bad++;
      if (bus.done === 1'b1) seen = 1;
    end
    chk({tag, "_done"}, 32'(seen), 32'd1);
    chk({tag, "_lat"}, cyc, 32'(s) + 32'd1);
    chk({tag, "_res"}, bus.result, exp);
    chk({tag, "_busy"}, busy_bad, 0);
    @(negedge clk);
    chk({tag, "_idle"}, {30'd0, bus.busy, bus.done}, 32'd0);
    chk({tag, "_hold"}, bus.result, exp);
  endtask

  initial begin
    int cyc;
    int ndone;
    int dcyc;
    logic [31:0] dres;
    logic [31:0] v;
    logic [4:0]  s;
    logic        a;

    checks = 0;
    errors = 0;
    bus.start = 1'b0;
    bus.num   = '0;
    bus.shamt = '0;
    bus.arith = 1'b0;
    rst_n = 1'b0;
    #23;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_res", bus.result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // reset in the middle of a long shift
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.num   = 32'h13579BDF;
    bus.shamt = 5'd20;
    bus.arith = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_busy", 32'(bus.busy), 32'd0);
    chk("mid_done", 32'(bus.done), 32'd0);
    chk("mid_res", bus.result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) ndone++;
    end
    chk("mid_nodone", ndone, 0);

    do_op(32'h13579BDF, 5'd5, 1'b0, 32'h009ABCDE, "lsr5");
    do_op(32'hF0000000, 5'd4, 1'b0, 32'h0F000000, "lsr4");
    do_op(32'hF0000000, 5'd4, 1'b1, 32'hFF000000, "asr4");
    do_op(32'h0000BEEF, 5'd0, 1'b0, 32'h0000BEEF, "zero");
    do_op(32'hFFFFFFFF, 5'd31, 1'b0, 32'h00000001, "lmax");
    do_op(32'hFFFFFFFF, 5'd31, 1'b1, 32'hFFFFFFFF, "amax");

    // start pulse while shifting must be ignored
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.num   = 32'h00001111;
    bus.shamt = 5'd8;
    bus.arith = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    ndone = 0;
    dcyc = 0;
    dres = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        ndone++;
        if (ndone == 1) begin
          dcyc = c;
          dres = bus.result;
        end
      end
      bus.start = (c == 3);
      if (c == 3) bus.num = 32'h11111111;
    end
    bus.start = 1'b0;
    chk("busy_ndone", ndone, 1);
    chk("busy_lat", dcyc, 9);
    chk("busy_res", dres, 32'h00000011);

    // back-to-back with start held through done
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.num   = 32'h00000001;
    bus.shamt = 5'd1;
    bus.arith = 1'b0;
    @(posedge clk); #1;
    bus.num   = 32'h80000000;
    bus.shamt = 5'd1;
    bus.arith = 1'b1;
    ndone = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 2) begin
        chk("b2b_d1", 32'(bus.done), 32'd1);
        chk("b2b_r1", bus.result, 32'd0);
      end
      if (c == 3) begin
        chk("b2b_idle", 32'(bus.busy), 32'd0);
        chk("b2b_hold", bus.result, 32'd0);
      end
      if (c == 5) begin
        chk("b2b_d2", 32'(bus.done), 32'd1);
        chk("b2b_r2", bus.result, 32'hC0000000);
      end
      if (bus.done === 1'b1) ndone++;
      if (c == 4) begin
        bus.start = 1'b0;
        bus.num   = $urandom;
        bus.arith = 1'b0;
      end
    end
    chk("b2b_ndone", ndone, 2);

    for (int k = 0; k < 30; k++) begin
      v = $urandom;
      s = 5'($urandom);
      a = 1'($urandom);
      if (k % 5 == 0) v[31] = 1'b1;
      do_op(v, s, a, ref_sr(v, int'(s), a), "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
